// File: rtl/x_meta_loader.sv
// Metadata chunk capture between the X streamer and X_data_scheduler.
// Extracts one unaligned chunk from one or two word-aligned beats.
module x_meta_loader #(
  parameter int BW              = 128,
  parameter int META_CHUNK_SIZE = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       meta_req_i,
  input  logic [ADDR_WIDTH-1:0]      meta_addr_i,
  input  logic [15:0]                meta_len_i,
  input  logic                       stream_valid_i,
  input  logic [BW-1:0]              stream_data_i,
  output logic                       stream_ready_o,
  output logic [META_CHUNK_SIZE-1:0] metadata_chunk_o,
  output logic                       meta_pending_o,
  output logic                       chunk_valid_o
);

  localparam int BWB = BW / 8;
  localparam int CB  = META_CHUNK_SIZE / 8;
  localparam int OW  = (BWB > 1) ? $clog2(BWB) : 1;
  localparam int MW  = META_CHUNK_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   off_q, off_d;
  logic [15:0]     len_q, len_d;
  logic            span_q, span_d;
  logic [BW-1:0]   lo_q, lo_d;
  logic [MW-1:0]   chunk_q, chunk_d;
  logic            cvalid_q, cvalid_d;
  logic            first_q, first_d;

  logic [ADDR_WIDTH-1:0] addr_mod;
  logic [OW-1:0]         off_in;
  logic [15:0]           len_in;
  logic                  span_in;
  logic                  hs;
  logic [OW+3:0]         lo_amt;
  logic [OW+3:0]         hi_amt;
  logic [BW-1:0]         beat_sh;
  logic [BW-1:0]         hi_sh;
  logic [BW-1:0]         two_raw;
  logic [MW-1:0]         mask;
  logic [MW-1:0]         one_beat;
  logic [MW-1:0]         two_beat;

  assign addr_mod = meta_addr_i % ADDR_WIDTH'(BWB);
  assign off_in   = addr_mod[OW-1:0];
  assign len_in   = (meta_len_i == 16'd0 || meta_len_i > 16'(CB))
                  ? 16'(CB) : meta_len_i;
  assign span_in  = (17'(off_in) + 17'(len_in)) > 17'(BWB);

  assign hs = stream_valid_i && stream_ready_o;

  // Low part of a split chunk is the tail of beat 0 moved to byte 0;
  // beat 1 is then placed just above it.
  assign lo_amt  = {1'b0, off_q, 3'b000};
  assign hi_amt  = {(OW+1)'(BWB) - {1'b0, off_q}, 3'b000};
  assign beat_sh = stream_data_i >> lo_amt;
  assign hi_sh   = stream_data_i << hi_amt;
  assign two_raw = lo_q | hi_sh;

  always_comb begin
    mask = '0;
    for (int k = 0; k < CB; k++) begin
      mask[k*8 +: 8] = (16'(k) < len_q) ? 8'hFF : 8'h00;
    end
  end

  assign one_beat = beat_sh[MW-1:0] & mask;
  assign two_beat = two_raw[MW-1:0] & mask;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q  <= IDLE;
      off_q    <= '0;
      len_q    <= '0;
      span_q   <= 1'b0;
      lo_q     <= '0;
      chunk_q  <= '0;
      cvalid_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      len_q    <= len_d;
      span_q   <= span_d;
      lo_q     <= lo_d;
      chunk_q  <= chunk_d;
      cvalid_q <= cvalid_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (meta_req_i) state_d = BEAT0;
      BEAT0: if (hs) state_d = span_q ? BEAT1 : DONE;
      BEAT1: if (hs) state_d = DONE;
      DONE:  if (!meta_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    off_d    = off_q;
    len_d    = len_q;
    span_d   = span_q;
    lo_d     = lo_q;
    chunk_d  = chunk_q;
    cvalid_d = cvalid_q;
    first_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (meta_req_i) begin
          off_d    = off_in;
          len_d    = len_in;
          span_d   = span_in;
          cvalid_d = 1'b0;
        end
      end
      BEAT0: begin
        if (hs && span_q) begin
          lo_d = beat_sh;
        end else if (hs) begin
          chunk_d  = one_beat;
          cvalid_d = 1'b1;
          first_d  = 1'b1;
        end
      end
      BEAT1: begin
        if (hs) begin
          chunk_d  = two_beat;
          cvalid_d = 1'b1;
          first_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stream_ready_o = (state_q == BEAT0) || (state_q == BEAT1);
    meta_pending_o = !((state_q == DONE) && first_q);
  end

  assign metadata_chunk_o = chunk_q;
  assign chunk_valid_o    = cvalid_q;

endmodule

// File: tb/tb_x_meta_loader.sv
// Randomised scoreboard bench for x_meta_loader.
// Driver pushes expected chunks; negedge monitor pops on each pulse.
module tb_x_meta_loader;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         req;
  logic [31:0]  addr;
  logic [15:0]  len;
  logic         svalid;
  logic [127:0] sdata;
  logic         sready;
  logic [31:0]  chunk;
  logic         pend;
  logic         cvalid;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_chunk = '0;
  bit mon_en = 1'b0;
  bit prev_pend = 1'b1;

  x_meta_loader #(
    .BW(128),
    .META_CHUNK_SIZE(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .meta_req_i(req),
    .meta_addr_i(addr),
    .meta_len_i(len),
    .stream_valid_i(svalid),
    .stream_data_i(sdata),
    .stream_ready_o(sready),
    .metadata_chunk_o(chunk),
    .meta_pending_o(pend),
    .chunk_valid_o(cvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [15:0] l);
    return (l == 0 || l > 4) ? 4 : int'(l);
  endfunction

  function automatic int span_of(input logic [31:0] a,
                                 input logic [15:0] l);
    return (int'(a % 16) + eff_len(l) > 16) ? 2 : 1;
  endfunction

  // Concatenate both beats as a byte array and read the window
  function automatic logic [31:0] ref_chunk(input logic [31:0] a,
                                            input logic [15:0] l,
                                            input logic [127:0] b0,
                                            input logic [127:0] b1);
    logic [7:0] arr[32];
    logic [31:0] r;
    int off;
    int le;
    for (int i = 0; i < 16; i++) begin
      arr[i]    = b0[i*8 +: 8];
      arr[16+i] = b1[i*8 +: 8];
    end
    off = int'(a % 16);
    le  = eff_len(l);
    r   = '0;
    for (int k = 0; k < 4; k++)
      if (k < le) r[k*8 +: 8] = arr[off+k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (!pend) begin
        if (!prev_pend) check("pulse_width", 32'(pend), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_chunk = exp_q.pop_front();
          check("chunk", chunk, exp_chunk);
          check("chunk_valid", 32'(cvalid), 32'd1);
          check("ready_in_done", 32'(sready), 32'd0);
        end
      end else begin
        check("chunk_stable", chunk, exp_chunk);
      end
      prev_pend = pend;
    end
  end

  task automatic run_txn(input logic [31:0] a,
                         input logic [15:0] l,
                         input logic [127:0] b0,
                         input logic [127:0] b1,
                         input bit do_clr);
    int nb;
    int cyc;
    int sp;
    bit v;
    sp  = span_of(a, l);
    nb  = 0;
    cyc = 0;
    @(negedge clk); #1;
    addr = a;
    len  = l;
    req  = 1'b1;
    svalid = 1'b0;
    while (nb < sp && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
      v = ($urandom % 3) != 0;
      sdata = (nb == 0) ? b0 : b1;
      if (do_clr && nb == 1 && sready) begin
        clear = 1'b1;
        svalid = 1'b1;
        exp_chunk = '0;
        @(negedge clk); #1;
        clear = 1'b0;
        svalid = 1'b0;
        req = 1'b0;
        check("clr_chunk", chunk, 32'd0);
        check("clr_valid", 32'(cvalid), 32'd0);
        check("clr_pend", 32'(pend), 32'd1);
        check("clr_ready", 32'(sready), 32'd0);
        @(negedge clk); #1;
        return;
      end
      svalid = v;
      if (v && sready) begin
        nb++;
        addr = $urandom;
        len  = 16'($urandom);
        if (nb == sp) exp_q.push_back(ref_chunk(a, l, b0, b1));
      end
    end
    if (nb < sp) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", nb, sp);
    end
    repeat ($urandom_range(1, 3) + 1) begin
      @(negedge clk); #1;
      check("ready_hold", 32'(sready), 32'd0);
      svalid = 1'($urandom % 2);
    end
    req = 1'b0;
    @(negedge clk); #1;
    check("ready_idle", 32'(sready), 32'd0);
    svalid = 1'b0;
  endtask

  logic [127:0] p0;
  logic [127:0] p1;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    req = 1'b0;
    addr = '0;
    len = '0;
    svalid = 1'b0;
    sdata = '0;
    for (int i = 0; i < 16; i++) begin
      p0[i*8 +: 8] = 8'(i);
      p1[i*8 +: 8] = 8'(16 + i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_chunk", chunk, 32'd0);
    check("rst_valid", 32'(cvalid), 32'd0);
    check("rst_pend", 32'(pend), 32'd1);
    check("rst_ready", 32'(sready), 32'd0);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_txn(32'h1000, 16'd4, p0, p1, 1'b0);
    run_txn(32'h1003, 16'd4, p0, p1, 1'b0);
    run_txn(32'h100E, 16'd4, p0, p1, 1'b0);
    run_txn(32'h1000, 16'd2, p0, p1, 1'b0);
    run_txn(32'h1000, 16'd0, p0, p1, 1'b0);
    run_txn(32'h100F, 16'd9, p0, p1, 1'b0);
    run_txn(32'h100E, 16'd4, p0, p1, 1'b1);
    run_txn(32'h1003, 16'd4, p0, p1, 1'b0);

    for (int t = 0; t < 150; t++) begin
      run_txn($urandom,
              16'($urandom_range(0, 7)),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              1'b0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
